// File: rtl/sd_spi_cmd_if.sv
// Request/response handshake between the card controller (master) and the
// SD SPI command engine (slave).
interface sd_spi_cmd_if;
  logic        start;
  logic        init;
  logic        fast;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic [1:0]  resp_type;
  logic [39:0] response;
  logic        done;
  logic        busy;
  logic        timeout;

  modport master (
    output start, init, fast, cmd, arg, resp_type,
    input  response, done, busy, timeout
  );

  modport slave (
    input  start, init, fast, cmd, arg, resp_type,
    output response, done, busy, timeout
  );
endinterface

// File: rtl/sd_spi_cmd.sv
// SD-card SPI-mode command engine: 48-bit command frames, R1/R1b/R3/R7 capture with timeouts.
// Define SD_SPI_CRC7_EN to compute the frame CRC7 in hardware instead of the fixed table.
module sd_spi_cmd #(
  parameter int CLK_DIV_SLOW   = 34,
  parameter int CLK_DIV_FAST   = 1,
  parameter int INIT_CLOCKS    = 80,
  parameter int TIMEOUT_CYCLES = 270000
) (
  input  logic        clk,
  input  logic        rst,
  sd_spi_cmd_if.slave host,
  input  logic        miso,
  output logic        mosi,
  output logic        sdclk,
  output logic        cs_n
);

  localparam int DIV_MAX = (CLK_DIV_SLOW > CLK_DIV_FAST) ? CLK_DIV_SLOW : CLK_DIV_FAST;
  localparam int DIV_W   = $clog2(DIV_MAX) + 1;
  localparam int CNT_MAX = (INIT_CLOCKS > 48) ? INIT_CLOCKS : 48;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INIT_CLK, SEND, WAIT_R, RECV, WAIT_BUSY, TRAIL
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt, div_lim;
  logic              sdclk_nxt, cs_n_nxt, mosi_nxt;
  logic [47:0]       shreg, shreg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, rx_len;
  logic [TW-1:0]     tmo, tmo_nxt;
  logic              fast_r, fast_nxt;
  logic [1:0]        rtype, rtype_nxt;
  logic              busy_r, busy_nxt;
  logic              done_r, done_nxt;
  logic              timeout_r, timeout_nxt;
  logic [39:0]       resp_r, resp_nxt;
  logic              strobe, rise, fall, tmo_hit;
  logic [39:0]       frame_head;
  logic [6:0]        crc;
  logic [47:0]       frame;

`ifdef SD_SPI_CRC7_EN
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign crc = crc7(frame_head);
`else
  assign crc = (host.cmd == 6'd0) ? 7'h4A :
               (host.cmd == 6'd8) ? 7'h43 : 7'h7F;
`endif

  assign frame_head = {2'b01, host.cmd, host.arg};
  assign frame      = {frame_head, crc, 1'b1};

  // sdclk toggles every DIV clk cycles; rise/fall mark the strobe that makes that edge.
  assign div_lim = fast_r ? DIV_W'(CLK_DIV_FAST - 1) : DIV_W'(CLK_DIV_SLOW - 1);
  assign strobe  = (state != IDLE) && (div_cnt == div_lim);
  assign rise    = strobe && !sdclk;
  assign fall    = strobe && sdclk;
  assign tmo_hit = (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign rx_len  = (rtype == 2'd2) ? CNT_W'(40) : CNT_W'(8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      sdclk     <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b1;
      shreg     <= '0;
      cnt       <= '0;
      tmo       <= '0;
      fast_r    <= 1'b0;
      rtype     <= 2'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      resp_r    <= '0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      sdclk     <= sdclk_nxt;
      cs_n      <= cs_n_nxt;
      mosi      <= mosi_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      tmo       <= tmo_nxt;
      fast_r    <= fast_nxt;
      rtype     <= rtype_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      timeout_r <= timeout_nxt;
      resp_r    <= resp_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    sdclk_nxt   = sdclk;
    cs_n_nxt    = cs_n;
    mosi_nxt    = mosi;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    tmo_nxt     = tmo;
    fast_nxt    = fast_r;
    rtype_nxt   = rtype;
    busy_nxt    = busy_r;
    done_nxt    = 1'b0;
    timeout_nxt = timeout_r;
    resp_nxt    = resp_r;

    if (state != IDLE) begin
      if (strobe) begin
        div_nxt   = '0;
        sdclk_nxt = ~sdclk;
      end else begin
        div_nxt = div_cnt + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        div_nxt   = '0;
        sdclk_nxt = 1'b0;
        if (host.init) begin
          state_nxt   = INIT_CLK;
          busy_nxt    = 1'b1;
          fast_nxt    = host.fast;
          timeout_nxt = 1'b0;
          resp_nxt    = '0;
          cs_n_nxt    = 1'b1;
          mosi_nxt    = 1'b1;
          cnt_nxt     = '0;
        end else if (host.start) begin
          state_nxt   = SEND;
          busy_nxt    = 1'b1;
          fast_nxt    = host.fast;
          rtype_nxt   = host.resp_type;
          timeout_nxt = 1'b0;
          resp_nxt    = '0;
          cs_n_nxt    = 1'b0;
          mosi_nxt    = frame[47];
          shreg_nxt   = {frame[46:0], 1'b0};
          cnt_nxt     = '0;
        end
      end

      // Both bursts count rising edges and finish on the falling edge that closes the last pulse.
      INIT_CLK, TRAIL: begin
        cs_n_nxt = 1'b1;
        mosi_nxt = 1'b1;
        if (rise) cnt_nxt = cnt + 1'b1;
        if (fall && cnt == ((state == INIT_CLK) ? CNT_W'(INIT_CLOCKS) : CNT_W'(8))) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end

      SEND: begin
        if (fall) begin
          if (cnt == CNT_W'(47)) begin
            mosi_nxt  = 1'b1;
            cnt_nxt   = '0;
            tmo_nxt   = '0;
            state_nxt = (rtype == 2'd3) ? TRAIL : WAIT_R;
          end else begin
            mosi_nxt  = shreg[47];
            shreg_nxt = {shreg[46:0], 1'b0};
            cnt_nxt   = cnt + 1'b1;
          end
        end
      end

      WAIT_R: begin
        mosi_nxt = 1'b1;
        tmo_nxt  = tmo + 1'b1;
        if (rise && !miso) begin
          resp_nxt  = '0;
          cnt_nxt   = CNT_W'(1);
          state_nxt = RECV;
        end else if (tmo_hit) begin
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = TRAIL;
        end
      end

      RECV: begin
        if (rise) begin
          resp_nxt = {resp_r[38:0], miso};
          cnt_nxt  = cnt + 1'b1;
          if (cnt + 1'b1 == rx_len) begin
            cnt_nxt = '0;
            tmo_nxt = '0;
            state_nxt = (rtype == 2'd1) ? WAIT_BUSY : TRAIL;
          end
        end
      end

      WAIT_BUSY: begin
        tmo_nxt = tmo + 1'b1;
        if (rise && miso) begin
          cnt_nxt   = '0;
          state_nxt = TRAIL;
        end else if (tmo_hit) begin
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = TRAIL;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign host.response = resp_r;
  assign host.done     = done_r;
  assign host.busy     = busy_r;
  assign host.timeout  = timeout_r;

endmodule
